// File: rtl/fetch_queue.sv
// fetch_queue: sequential-prefetch fetch front-end feeding decode from a DEPTH-entry {pc, inst} queue,
// with single-outstanding variable-latency memory requests and one-cycle redirect flush.
module fetch_queue #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32,
  parameter int DEPTH = 4,
  parameter int unsigned PC_STEP = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst_n,
  output logic imem_req_valid,
  input  logic imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic inst_valid,
  input  logic inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [ADDR_W-1:0] fetch_pc, req_pc;
  logic outstanding, drop;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [INST_W-1:0] data_q [DEPTH];
  logic req_fire, rsp_take, push, pop;
  // the in-flight request already owns a slot, so issue never overflows the queue
  assign imem_req_valid = rst_n && !redirect_valid && (!outstanding || imem_rsp_valid) &&
                          (({1'b0, count} + (CW+1)'(outstanding)) < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_take = outstanding && imem_rsp_valid;
  assign push = rsp_take && !drop && !redirect_valid;
  assign inst_valid = (count != '0) && !redirect_valid;
  assign pop = inst_valid && inst_ready;
  assign inst_data = (count != '0) ? data_q[rd_ptr] : '0;
  assign inst_pc = (count != '0) ? pc_q[rd_ptr] : '0;
  assign occupancy = count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc <= '0;
      outstanding <= 1'b0;
      drop <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      drop <= outstanding && !imem_rsp_valid;
      outstanding <= outstanding && !imem_rsp_valid;
    end else begin
      if (req_fire) begin
        req_pc <= fetch_pc;
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      end
      outstanding <= req_fire || (outstanding && !imem_rsp_valid);
      if (rsp_take) drop <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      pc_q[wr_ptr] <= req_pc;
      data_q[wr_ptr] <= imem_rsp_data;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed stimulus against a queue-level reference model of the fetch front-end.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [63:0] STEP = 64'd4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [63:0] imem_addr, redirect_pc = '0, inst_pc;
  logic [31:0] imem_rsp_data = '0, inst_data;
  logic redirect_valid = 1'b0, inst_valid, inst_ready = 1'b0;
  logic [2:0] occupancy;

  fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc), .occupancy(occupancy));

  always #5 clk = ~clk;

  typedef struct { int due; logic [63:0] addr; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] d; } ent_t;
  mreq_t memq[$];
  ent_t q[$];
  logic [63:0] m_fpc = '0, m_rpc = '0;
  bit m_out, m_drop, hold;
  int cyc_n, lat_lo = 1, lat_hi = 1, checks, errors;
  logic [63:0] hs_addr[$], pop_pc[$];
  logic [31:0] pop_d[$];
  int hs_cyc[$], pop_cyc[$];

  function automatic logic [31:0] f(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc_n);
    end
  endtask

  function automatic logic [63:0] pop_at(input int i);
    return (pop_pc.size() > i) ? pop_pc[i] : '1;
  endfunction

  function automatic logic [63:0] hs_at(input int i);
    return (hs_addr.size() > i) ? hs_addr[i] : '1;
  endfunction

  task automatic step(input bit rdr, input logic [63:0] rpc, input bit ir, input bit qr);
    bit rsp, ev, erv, dhs, qre;
    logic [63:0] a_s;
    @(negedge clk);
    qre = qr && !hold;
    redirect_valid = rdr; redirect_pc = rpc; inst_ready = ir; imem_req_ready = qre;
    rsp = memq.size() != 0 && memq[0].due <= cyc_n;
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? f(memq[0].addr) : $urandom;
    #1;
    ev = rst_n && q.size() != 0 && !rdr;
    erv = rst_n && !rdr && (!m_out || rsp) && (q.size() + int'(m_out)) < DEPTH;
    chk("inst_valid", inst_valid, ev);
    chk("req_valid", imem_req_valid, erv);
    chk("occupancy", occupancy, q.size());
    chk("imem_addr", imem_addr, m_fpc);
    if (ev) begin
      chk("inst_pc", inst_pc, q[0].pc);
      chk("inst_data", inst_data, q[0].d);
    end
    if (!rst_n) begin
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_inst_data", inst_data, 0);
    end
    a_s = imem_addr;
    dhs = imem_req_valid && qre;
    if (dhs) begin hs_addr.push_back(a_s); hs_cyc.push_back(cyc_n); end
    if (inst_valid && ir) begin pop_pc.push_back(inst_pc); pop_d.push_back(inst_data); pop_cyc.push_back(cyc_n); end
    @(posedge clk);
    if (rsp) void'(memq.pop_front());
    if (dhs) memq.push_back('{cyc_n + $urandom_range(lat_hi, lat_lo), a_s});
    if (rst_n) begin
      if (rdr) begin
        q.delete();
        m_fpc = rpc;
        if (m_out) begin m_drop = !rsp; m_out = !rsp; end
      end else begin
        if (q.size() != 0 && ir) void'(q.pop_front());
        if (m_out && rsp) begin
          if (!m_drop) q.push_back('{m_rpc, f(m_rpc)});
          m_drop = 0; m_out = 0;
        end
        if (erv && qre) begin m_rpc = m_fpc; m_fpc = m_fpc + STEP; m_out = 1; end
      end
    end
    if (hold && memq.size() == 0) hold = 0;
    cyc_n++;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete(); m_fpc = '0; m_out = 0; m_drop = 0;
    hold = memq.size() != 0;
    repeat (n) step(0, '0, 1, 1);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int p0, h0, due8, rc, bad;
    bit found;
    // 1: L=1 streaming
    do_reset(2);
    h0 = hs_cyc.size(); p0 = pop_pc.size();
    repeat (8) step(0, '0, 1, 1);
    chk("t1_npop", pop_pc.size() - p0 >= 4, 1);
    chk("t1_pc0", pop_at(p0), 64'h0);
    chk("t1_pc1", pop_at(p0+1), 64'h4);
    chk("t1_pc2", pop_at(p0+2), 64'h8);
    chk("t1_pc3", pop_at(p0+3), 64'hC);
    if (pop_cyc.size() > p0 + 3 && hs_cyc.size() > h0) begin
      chk("t1_latency", pop_cyc[p0] - hs_cyc[h0], 2);
      chk("t1_rate", pop_cyc[p0+3] - pop_cyc[p0], 3);
      chk("t1_data", pop_d[p0], 32'h1234_5678);
    end
    // 2: decode stalled from reset until full
    do_reset(1);
    repeat (10) step(0, '0, 0, 1);
    #1;
    chk("t2_occ", occupancy, 4);
    chk("t2_reqv", imem_req_valid, 0);
    chk("t2_head", inst_pc, 64'h0);
    h0 = hs_addr.size(); p0 = pop_pc.size();
    repeat (10) step(0, '0, 1, 1);
    chk("t2_d0", pop_at(p0), 64'h0);
    chk("t2_d1", pop_at(p0+1), 64'h4);
    chk("t2_d2", pop_at(p0+2), 64'h8);
    chk("t2_d3", pop_at(p0+3), 64'hC);
    chk("t2_resume", hs_at(h0), 64'h10);
    // 3: redirect while 0x8 is in flight with L=3
    lat_lo = 3; lat_hi = 3;
    do_reset(1);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(0, '0, 1, 1);
      found = memq.size() != 0 && memq[0].addr == 64'h8;
    end
    chk("t3_found", found, 1);
    due8 = found ? memq[0].due : 0;
    h0 = hs_addr.size(); p0 = pop_pc.size();
    step(1, 64'h100, 1, 1);
    repeat (15) step(0, '0, 1, 1);
    bad = 0;
    for (int i = p0; i < pop_pc.size(); i++) if (pop_pc[i] == 64'h8) bad++;
    chk("t3_no8", bad, 0);
    chk("t3_next", pop_at(p0), 64'h100);
    chk("t3_req", hs_at(h0), 64'h100);
    if (hs_cyc.size() > h0) chk("t3_req_cyc", hs_cyc[h0], due8);
    // 4: redirect coincident with response and pending pop
    lat_lo = 1; lat_hi = 1;
    do_reset(1);
    repeat (4) step(0, '0, 1, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      found = memq.size() != 0 && memq[0].due <= cyc_n && q.size() != 0;
      if (!found) step(0, '0, 1, 1);
    end
    chk("t4_found", found, 1);
    rc = cyc_n; h0 = hs_addr.size(); p0 = pop_pc.size();
    step(1, 64'h40, 1, 1);
    chk("t4_nopop", pop_pc.size() - p0, 0);
    repeat (6) step(0, '0, 1, 1);
    chk("t4_req", hs_at(h0), 64'h40);
    if (hs_cyc.size() > h0) chk("t4_req_cyc", hs_cyc[h0], rc + 1);
    chk("t4_next", pop_at(p0), 64'h40);
    // 5: back-to-back redirects
    lat_lo = 2; lat_hi = 2;
    do_reset(1);
    repeat (5) step(0, '0, 1, 1);
    h0 = hs_addr.size(); p0 = pop_pc.size();
    step(1, 64'h200, 1, 1);
    step(1, 64'h300, 1, 1);
    repeat (15) step(0, '0, 1, 1);
    bad = 0;
    for (int i = p0; i < pop_pc.size(); i++) if (pop_pc[i] >= 64'h200 && pop_pc[i] < 64'h300) bad++;
    for (int i = h0; i < hs_addr.size(); i++) if (hs_addr[i] == 64'h200) bad++;
    chk("t5_no200", bad, 0);
    chk("t5_next", pop_at(p0), 64'h300);
    chk("t5_req", hs_at(h0), 64'h300);
    // 6: reset with a request in flight
    lat_lo = 3; lat_hi = 3;
    do_reset(1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, '0, 1, 1);
      found = memq.size() != 0 && memq[0].addr == 64'h4;
    end
    chk("t6_found", found, 1);
    do_reset(1);
    h0 = hs_addr.size(); p0 = pop_pc.size();
    repeat (12) step(0, '0, 1, 1);
    chk("t6_req", hs_at(h0), 64'h0);
    chk("t6_pop", pop_at(p0), 64'h0);
    if (pop_d.size() > p0) chk("t6_data", pop_d[p0], 32'h1234_5678);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rpc;
      lat_lo = 1; lat_hi = 4;
      rpc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
      else step($urandom_range(0, 19) == 0, rpc, (i % 600 < 100) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
                $urandom_range(0, 3) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised fetch front-end for the pipelined ARMv8 core. It replaces the fixed PC register, +4 adder and stall-gated IF/ID latch with a prefetch queue of DEPTH entries.
- Generates sequential fetch addresses and talks to instruction memory over a variable-latency valid/ready request and response interface.
- Hands {pc, instruction} pairs to decode with a valid/ready handshake. A decode stall is expressed as inst_ready=0.
- On a branch redirect it flushes all queued and in-flight fetches in one cycle.

Parameters:
- ADDR_W, 64: PC and address width.
- INST_W, 32: instruction width.
- DEPTH, 4: queue entries. Must be a power of two and at least 2.
- PC_STEP, 4: sequential PC increment.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  ADDR_W  fetch address; equals fetch_pc.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  INST_W  fetched instruction.
- redirect_valid  in  1  branch taken or flush request.
- redirect_pc  in  ADDR_W  new fetch PC.
- inst_valid  out  1  queue head is valid.
- inst_ready  in  1  decode accepts the head; 0 means stall.
- inst_data  out  INST_W  head instruction.
- inst_pc  out  ADDR_W  head PC.
- occupancy  out  $clog2(DEPTH+1)  number of queued entries.

Behaviour:
- State: fetch_pc, req_pc, outstanding, drop, rd_ptr, wr_ptr, count. Pointers are log2(DEPTH) bits and wrap naturally.
- Reset (Reset=0, asynchronous):
  - fetch_pc=RESET_PC; count, pointers, outstanding and drop =0.
  - Outputs: inst_valid=0, imem_req_valid=0, occupancy=0. inst_data and inst_pc read 0.
- At most one memory request is outstanding.
- imem_req_valid (combinational) = !redirect_valid && (!outstanding || imem_rsp_valid) && (count + outstanding) < DEPTH.
  - The dequeue in the same cycle is ignored, which is conservative.
  - A slot is reserved at issue, so the queue never overflows.
- Request handshake (imem_req_valid && imem_req_ready): req_pc<=fetch_pc; fetch_pc<=fetch_pc+PC_STEP (wraps mod 2^ADDR_W); outstanding<=1.
- Response:
  - imem_rsp_valid is ignored while outstanding=0.
  - With outstanding=1 and drop=1: data is discarded; outstanding and drop clear.
  - Otherwise: push {req_pc, imem_rsp_data} at wr_ptr; outstanding clears unless a new request handshakes in the same cycle.
- Dequeue: inst_valid = (count!=0) && !redirect_valid; pop on inst_valid && inst_ready. A push and a pop in the same cycle leave count unchanged.
- Latency: request accepted at cycle t, response at t+L, inst_valid at t+L+1. There is no bypass from response to output.
- Throughput: with L=1 and inst_ready=1, steady state is one instruction per cycle.
- Redirect has the highest priority. In the redirect cycle:
  - count, rd_ptr and wr_ptr clear to 0; fetch_pc<=redirect_pc; no request and no pop.
  - A response arriving in the same cycle is discarded and outstanding clears.
  - If a request is outstanding and no response arrives that cycle, drop<=1.
  - The first post-redirect request is issued the next cycle, or later if a dropped response is still pending.
- Back-to-back redirects: the last one wins. drop stays set until the stale response returns.
- Full queue (count=DEPTH): no request is issued; the head stays stable while inst_ready=0.
- Stability: inst_data and inst_pc are held stable while inst_valid=1 and inst_ready=0.
- Reset asserted mid-operation: all state clears immediately. A stale response arriving after reset is ignored because outstanding=0.

Test Plan:
1. Reset release; memory with L=1 and always ready; inst_ready=1. inst_pc sequence is 0x0, 0x4, 0x8, 0xC at one per cycle, first inst_valid 2 cycles after the first request. Data matches memory.
2. Hold inst_ready=0 from reset with DEPTH=4. occupancy reaches 4, imem_req_valid=0, head stays pc=0x0. Release: pcs 0x0…0xC drain in order, then fetch resumes at 0x10.
3. L=3 memory; assert redirect_valid with redirect_pc=0x100 while a fetch of 0x8 is outstanding. Queue empties, the 0x8 response is dropped, and the next inst_pc is 0x100.
4. Redirect in the same cycle as a response and a pending pop. No instruction is dequeued and the response is discarded. The next request address is redirect_pc=0x40.
5. Two redirects on consecutive cycles to 0x200 and then 0x300. Only 0x300 is fetched; no 0x200 instruction is ever valid.
6. Assert Reset=0 mid-stream with a request outstanding, then release. The late stale response is ignored and fetch restarts at RESET_PC with occupancy=0.
